hsaf_conv_monitor: RTL and testbench

Convergence and divergence monitor placed directly downstream of the log-domain Hammerstein spline adaptive filter. It consumes the filter's registered error sample stream (`error_d`) and squares each sample. It averages the squares over fixed power-of-two windows to produce a windowed MSE. A small state machine then reports whether adaptation has converged (MSE below threshold for HOLD consecutive windows) or diverged (MSE above a scaled threshold); the diverged condition is sticky until software clears it.

---
 rtl/hsaf_conv_monitor.sv | 224 ++++++++++++++++++++++
 tb/tb_hsaf_conv_monitor.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hsaf_conv_monitor.sv
// Windowed-MSE convergence/divergence monitor for the Hammerstein spline adaptive filter error stream.
// Optional peak |error| output is enabled by defining HSAF_CONV_MON_PEAK_EN.
module hsaf_conv_monitor #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned WIN_LOG2  = 6,
    parameter int unsigned HOLD      = 4,
    parameter int unsigned DIV_SHIFT = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      valid_in,
    input  logic signed [WIDTH-1:0]   error_in,
    input  logic [2*WIDTH-1:0]        mse_thresh,
    input  logic                      clear_div,
    output logic [2*WIDTH-1:0]        mse_out,
    output logic                      mse_valid,
    output logic                      converged,
    output logic                      diverged,
    output logic [1:0]                state,
    output logic [WIN_LOG2-1:0]       win_count
`ifdef HSAF_CONV_MON_PEAK_EN
    ,
    output logic [WIDTH-2:0]          peak_err
`endif
);

    localparam int unsigned SQ_W  = 2 * WIDTH;
    localparam int unsigned ACC_W = SQ_W + WIN_LOG2;
    localparam int unsigned THR_W = SQ_W + DIV_SHIFT;
    localparam logic [3:0]  HOLD_C = 4'(HOLD);

    typedef enum logic [1:0] {
        ST_ACQUIRE   = 2'b00,
        ST_CONVERGED = 2'b01,
        ST_DIVERGED  = 2'b10
    } state_e;

    logic [WIN_LOG2-1:0]      win_count_q;
    logic                     last_d;

    logic signed [WIDTH-1:0]  err0_q;
    logic                     v0_q, l0_q;

    logic signed [SQ_W-1:0]   prod_d;
    logic [SQ_W-1:0]          sq1_q;
    logic                     v1_q, l1_q;

    logic [ACC_W-1:0]         acc_q, sum_d;
    logic [SQ_W-1:0]          mse_out_q;
    logic                     mse_valid_q;

    logic [THR_W-1:0]         thr_wide_d;
    logic [SQ_W-1:0]          div_thr_d;

    state_e                   state_q;
    logic [3:0]               below_cnt_q, below_nxt_d;
    logic                     converged_q, diverged_q;

    assign last_d = valid_in && (win_count_q == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            win_count_q <= '0;
        end else if (valid_in) begin
            win_count_q <= win_count_q + 1'b1;
        end
    end

    // Input capture stage: the sample is accepted here, squared in the next stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            v0_q <= 1'b0;
            l0_q <= 1'b0;
        end else begin
            v0_q <= valid_in;
            l0_q <= last_d;
        end
        if (valid_in) begin
            err0_q <= error_in;
        end
    end

    always_comb begin
        prod_d = err0_q * err0_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q <= 1'b0;
            l1_q <= 1'b0;
        end else begin
            v1_q <= v0_q;
            l1_q <= l0_q;
        end
        if (v0_q) begin
            sq1_q <= prod_d;
        end
    end

    always_comb begin
        sum_d = acc_q + ACC_W'(sq1_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            mse_out_q   <= '0;
            mse_valid_q <= 1'b0;
        end else begin
            mse_valid_q <= 1'b0;
            if (v1_q) begin
                if (l1_q) begin
                    mse_out_q   <= sum_d[WIN_LOG2 +: SQ_W];
                    mse_valid_q <= 1'b1;
                    acc_q       <= '0;
                end else begin
                    acc_q <= sum_d;
                end
            end
        end
    end

    // Scaled divergence threshold saturates instead of wrapping.
    always_comb begin
        thr_wide_d = THR_W'(mse_thresh) << DIV_SHIFT;
        div_thr_d  = ((thr_wide_d >> SQ_W) != '0) ? '1 : thr_wide_d[SQ_W-1:0];
        below_nxt_d = below_cnt_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_ACQUIRE;
            below_cnt_q <= '0;
            converged_q <= 1'b0;
            diverged_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_ACQUIRE: begin
                    if (mse_valid_q) begin
                        if (mse_out_q >= div_thr_d) begin
                            state_q    <= ST_DIVERGED;
                            diverged_q <= 1'b1;
                        end else if (mse_out_q < mse_thresh) begin
                            if (below_nxt_d == HOLD_C) begin
                                state_q     <= ST_CONVERGED;
                                converged_q <= 1'b1;
                                below_cnt_q <= '0;
                            end else begin
                                below_cnt_q <= below_nxt_d;
                            end
                        end else begin
                            below_cnt_q <= '0;
                        end
                    end
                end
                ST_CONVERGED: begin
                    if (mse_valid_q) begin
                        if (mse_out_q >= div_thr_d) begin
                            state_q     <= ST_DIVERGED;
                            converged_q <= 1'b0;
                            diverged_q  <= 1'b1;
                        end else if (mse_out_q >= mse_thresh) begin
                            state_q     <= ST_ACQUIRE;
                            converged_q <= 1'b0;
                            below_cnt_q <= '0;
                        end
                    end
                end
                ST_DIVERGED: begin
                    if (clear_div) begin
                        state_q     <= ST_ACQUIRE;
                        diverged_q  <= 1'b0;
                        below_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q     <= ST_ACQUIRE;
                    converged_q <= 1'b0;
                    diverged_q  <= 1'b0;
                    below_cnt_q <= '0;
                end
            endcase
        end
    end

`ifdef HSAF_CONV_MON_PEAK_EN
    logic [WIDTH-1:0] mag0_d;
    logic [WIDTH-2:0] abs0_d, abs1_q, pk_acc_q, pk_max_d, peak_q;

    // The most negative sample has no positive counterpart, so clip it.
    always_comb begin
        mag0_d   = err0_q[WIDTH-1] ? (~err0_q + 1'b1) : err0_q;
        abs0_d   = mag0_d[WIDTH-1] ? '1 : mag0_d[WIDTH-2:0];
        pk_max_d = (abs1_q > pk_acc_q) ? abs1_q : pk_acc_q;
    end

    always_ff @(posedge clk) begin
        if (v0_q) begin
            abs1_q <= abs0_d;
        end
        if (reset) begin
            pk_acc_q <= '0;
            peak_q   <= '0;
        end else if (v1_q) begin
            if (l1_q) begin
                peak_q   <= pk_max_d;
                pk_acc_q <= '0;
            end else begin
                pk_acc_q <= pk_max_d;
            end
        end
    end

    assign peak_err = peak_q;
`endif

    assign win_count = win_count_q;
    assign mse_out   = mse_out_q;
    assign mse_valid = mse_valid_q;
    assign converged = converged_q;
    assign diverged  = diverged_q;
    assign state     = state_q;

endmodule

// File: tb/tb_hsaf_conv_monitor.sv
// Bench for hsaf_conv_monitor: window-level reference model plus directed literal checks and random traffic.
module tb_hsaf_conv_monitor;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               valid_in = 1'b0;
    logic signed [15:0] error_in = '0;
    logic [31:0]        mse_thresh = '0;
    logic               clear_div = 1'b0;
    logic [31:0]        mse_out;
    logic               mse_valid;
    logic               converged;
    logic               diverged;
    logic [1:0]         state;
    logic [5:0]         win_count;
`ifdef HSAF_CONV_MON_PEAK_EN
    logic [14:0]        peak_err;
`endif

    always #5 clk = ~clk;

    hsaf_conv_monitor #(
        .WIDTH(16), .WIN_LOG2(6), .HOLD(4), .DIV_SHIFT(3)
    ) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .error_in(error_in),
        .mse_thresh(mse_thresh), .clear_div(clear_div),
        .mse_out(mse_out), .mse_valid(mse_valid), .converged(converged),
        .diverged(diverged), .state(state), .win_count(win_count)
`ifdef HSAF_CONV_MON_PEAK_EN
        , .peak_err(peak_err)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: window results are scheduled as events two edges after the
    // edge that accepts the 64th sample; the FSM consumes the result visible before each edge.
    typedef struct {
        longint due;
        longint mse;
        int     peak;
    } win_ev_t;

    win_ev_t     m_evq[$];
    longint      cyc = 0;
    longint      m_sum = 0;
    int          m_cnt = 0;
    int          m_peak = 0;
    logic [31:0] e_mse = '0;
    bit          e_mv = 1'b0;
    int          e_state = 0;
    int          e_below = 0;
    int          e_peak = 0;

    always @(posedge clk) begin
        longint unsigned thr, dthr;
        int ev, mag;
        cyc++;
        if (reset) begin
            m_evq.delete();
            m_sum = 0; m_cnt = 0; m_peak = 0;
            e_mse = '0; e_mv = 1'b0; e_state = 0; e_below = 0; e_peak = 0;
        end else begin
            thr  = longint'(mse_thresh);
            dthr = thr * 8;
            if (dthr > 64'hFFFF_FFFF) dthr = 64'hFFFF_FFFF;
            case (e_state)
                0: if (e_mv) begin
                    if (e_mse >= dthr) e_state = 2;
                    else if (e_mse < thr) begin
                        e_below++;
                        if (e_below == 4) begin e_state = 1; e_below = 0; end
                    end else e_below = 0;
                end
                1: if (e_mv) begin
                    if (e_mse >= dthr) e_state = 2;
                    else if (e_mse >= thr) begin e_state = 0; e_below = 0; end
                end
                default: if (clear_div) begin e_state = 0; e_below = 0; end
            endcase
            e_mv = 1'b0;
            if (m_evq.size() > 0 && m_evq[0].due == cyc) begin
                e_mv   = 1'b1;
                e_mse  = 32'(m_evq[0].mse);
                e_peak = m_evq[0].peak;
                void'(m_evq.pop_front());
            end
            if (valid_in) begin
                ev = int'(error_in);
                m_sum += longint'(ev) * longint'(ev);
                mag = (ev < 0) ? -ev : ev;
                if (mag > 32767) mag = 32767;
                if (mag > m_peak) m_peak = mag;
                m_cnt++;
                if (m_cnt == 64) begin
                    m_evq.push_back('{due: cyc + 2, mse: m_sum / 64, peak: m_peak});
                    m_sum = 0; m_cnt = 0; m_peak = 0;
                end
            end
        end
        #1;
        chk("mse_valid", 64'(mse_valid), 64'(e_mv));
        chk("mse_out",   64'(mse_out),   64'(e_mse));
        chk("state",     64'(state),     64'(e_state));
        chk("converged", 64'(converged), 64'(e_state == 1));
        chk("diverged",  64'(diverged),  64'(e_state == 2));
        chk("win_count", 64'(win_count), 64'(m_cnt));
`ifdef HSAF_CONV_MON_PEAK_EN
        chk("peak_err",  64'(peak_err),  64'(e_peak));
`endif
    end

    task automatic wait_mv(input int budget, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (mse_valid === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s: no mse_valid within %0d cycles", name, budget);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n, mv_cnt, amp;
        longint last_t, prev_t;

        repeat (3) @(negedge clk);
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_mse", 64'(mse_out), 64'd0);
        chk("rst_mv", 64'(mse_valid), 64'd0);
        chk("rst_wc", 64'(win_count), 64'd0);

        // Constant 16 -> 256 per window, converges after the fourth window.
        mse_thresh = 32'd300;
        error_in = 16'sd16;
        valid_in = 1'b1;
        reset = 1'b0;
        n = 0;
        while (mse_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk("first_latency", 64'(n), 64'd66);
        chk("A_mse", 64'(mse_out), 64'd256);
        wait_mv(80, "A_w2");
        wait_mv(80, "A_w3");
        wait_mv(80, "A_w4");
        chk("A_conv_before", 64'(converged), 64'd0);
        @(negedge clk);
        chk("A_conv_after", 64'(converged), 64'd1);
        chk("A_state", 64'(state), 64'd1);

        // Large error -> diverged; clear coincident with a window result wins.
        error_in = 16'sd1000;
        wait_mv(80, "B_div_win");
        @(negedge clk);
        chk("B_state_div", 64'(state), 64'd2);
        chk("B_diverged", 64'(diverged), 64'd1);
        wait_mv(80, "B_full_win");
        chk("B_mse", 64'(mse_out), 64'd1000000);
        clear_div = 1'b1;
        @(negedge clk);
        clear_div = 1'b0;
        chk("B_clear_state", 64'(state), 64'd0);
        chk("B_clear_div", 64'(diverged), 64'd0);

        // Alternating +/-100 with threshold 5000: stays in ACQUIRE.
        mse_thresh = 32'd5000;
        do_reset(1);
        mv_cnt = 0;
        for (int i = 0; i < 210; i++) begin
            error_in = (i % 2 == 0) ? 16'sd100 : -16'sd100;
            @(negedge clk);
            if (mse_valid === 1'b1) begin
                mv_cnt++;
                chk("C_mse", 64'(mse_out), 64'd10000);
            end
        end
        chk("C_windows", 64'(mv_cnt), 64'd3);
        chk("C_state", 64'(state), 64'd0);

        // Most negative sample squared fits exactly.
        error_in = -16'sd32768;
        wait_mv(80, "D_w1");
        wait_mv(80, "D_w2");
        wait_mv(80, "D_w3");
        chk("D_mse", 64'(mse_out), 64'h4000_0000);
`ifdef HSAF_CONV_MON_PEAK_EN
        chk("D_peak", 64'(peak_err), 64'h7FFF);
`endif

        // Half-rate valid: one window per 128 cycles.
        error_in = 16'sd16;
        last_t = 0; prev_t = 0;
        for (int i = 0; i < 520; i++) begin
            valid_in = (i % 2 == 0);
            @(negedge clk);
            if (mse_valid === 1'b1) begin prev_t = last_t; last_t = i; end
        end
        chk("E_period", 64'(last_t - prev_t), 64'd128);
        valid_in = 1'b1;
        wait_mv(140, "E_last");
        chk("E_mse", 64'(mse_out), 64'd256);

        // Reset at win_count 30 discards the partial window.
        n = 0;
        while (win_count !== 6'd30 && n < 100) begin @(negedge clk); n++; end
        chk("F_reach30", 64'(win_count), 64'd30);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("F_wc0", 64'(win_count), 64'd0);
        chk("F_mse0", 64'(mse_out), 64'd0);
        chk("F_state0", 64'(state), 64'd0);
        n = 0;
        while (mse_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk("F_latency", 64'(n), 64'd66);

        // Random traffic against the model.
        amp = 24;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) begin
                case ($urandom_range(0, 4))
                    0: amp = 8;
                    1: amp = 24;
                    2: amp = 40;
                    3: amp = 300;
                    default: amp = 4000;
                endcase
            end
            if ($urandom_range(0, 199) == 0) begin
                case ($urandom_range(0, 3))
                    0: mse_thresh = 32'd300;
                    1: mse_thresh = 32'd0;
                    2: mse_thresh = 32'hF000_0000;
                    default: mse_thresh = 32'd2000;
                endcase
            end
            valid_in  = ($urandom_range(0, 9) != 0);
            error_in  = 16'(int'($urandom_range(0, 2 * amp)) - amp);
            clear_div = ($urandom_range(0, 19) == 0);
            reset     = ($urandom_range(0, 999) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        clear_div = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
